mem_arbiter: RTL

//  Two-port round-robin arbiter/sequencer in front of the single-port 8x26 data

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter and sequencer in front of the single-port
// 8x26 data memory. Port 0 (CPU core) and port 1 (loader/debug host) each
// issue one read or write at a time over a req/ack handshake. Accesses are
// serialised, the memory's in/addr/we are driven from latched command
// registers, and read data is returned on the winning port.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   p0_req       port 0 request; command fields held stable until p0_ack
//   p0_we        port 0 write (1) / read (0)
//   p0_addr      port 0 word address (AW bits)
//   p0_wdata     port 0 write data
//   p0_ack       port 0 one-cycle completion pulse
//   p0_rdata     port 0 read data, valid with p0_ack, held until next read ack
//   p1_*         same set for port 1
//   mem_in       memory data input
//   mem_addr     memory address, AW-bit address zero-extended to DW bits
//   mem_we       memory write enable, only ever high during ACCESS
//   mem_out      memory combinational read data for mem_addr
//   busy         high whenever the sequencer is not IDLE
//
// States
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for a request; arbitrates and latches the winner
//   S_ACCESS | memory driven with latched command; write/read at cycle end
//   S_RESP   | winner's ack pulsed; back to IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DW = 26,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,

    output logic [DW-1:0] mem_in,
    output logic [DW-1:0] mem_addr,
    output logic          mem_we,
    input  logic [DW-1:0] mem_out,

    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // rr_last holds the id of the most recent winner; on contention the
    // other port is granted. Reset value 1 lets port 0 win first contention.
    logic          rr_last;

    logic          cmd_port;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          grant_valid;
    logic          grant_port;
    logic          grant_we;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_wdata;

    // -----------------------------------------------------------------------
    // Arbitration: a lone requester always wins; under contention the port
    // that did not win last time is chosen.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_valid = p0_req | p1_req;
        grant_port  = 1'b0;
        if (p0_req && p1_req) begin
            grant_port = ~rr_last;
        end else if (p1_req) begin
            grant_port = 1'b1;
        end

        if (grant_port) begin
            grant_we    = p1_we;
            grant_addr  = p1_addr;
            grant_wdata = p1_wdata;
        end else begin
            grant_we    = p0_we;
            grant_addr  = p0_addr;
            grant_wdata = p0_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs. mem_we and the acks decode the
    // state directly so an asynchronous reset removes them immediately,
    // which is what aborts a write caught mid-ACCESS.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        busy      = 1'b1;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_valid) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_we    = cmd_we;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                p0_ack    = ~cmd_port;
                p1_ack    = cmd_port;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address and data come straight from the command registers so they
    // stay at the last latched values outside ACCESS instead of following
    // whatever the requesters are driving.
    assign mem_addr = {{(DW-AW){1'b0}}, cmd_addr};
    assign mem_in   = cmd_wdata;

    // -----------------------------------------------------------------------
    // Command latch and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last   <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == S_IDLE && grant_valid) begin
            rr_last   <= grant_port;
            cmd_port  <= grant_port;
            cmd_we    <= grant_we;
            cmd_addr  <= grant_addr;
            cmd_wdata <= grant_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read data return: captured at the edge closing ACCESS into the
    // winner's register only; writes leave both registers untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == S_ACCESS && !cmd_we) begin
            if (cmd_port) begin
                p1_rdata <= mem_out;
            end else begin
                p0_rdata <= mem_out;
            end
        end
    end

endmodule
